dp_alu_stage: RTL and testbench
===============================

# dp_alu_stage

Execute stage for ARM data-processing instructions, directly downstream of the op2 shifter. Each cycle it accepts one decoded beat carrying operand 1, the shifted operand 2 and the shifter carry, then:
- evaluates the condition field against the architectural NZCV flags it owns;
- computes one of the 16 data-processing opcodes;
- commits the flags;
- presents a registered writeback beat to the register-file stage over a valid/ready handshake.

It also feeds the current C flag back to the shifter as its carry-in.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush (branch/exception)
- in_valid  in  1  input beat present
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_cond  in  4  ARM condition field [31:28]
- in_opcode  in  4  data-processing opcode [24:21]
- in_s  in  1  S bit
- in_rd  in  4  destination register
- in_op1  in  32  Rn value
- in_op2  in  32  shifted operand from op2 shifter
- in_shift_c  in  1  shifter carry-out
- flag_c  out  1  current C flag, drives shifter c_in
- flags_nzcv  out  4  architectural flags {N,Z,C,V}
- out_valid  out  1  writeback beat present
- out_ready  in  1  consumer accepts beat
- out_we  out  1  result is to be written to out_rd
- out_rd  out  4  destination register
- out_result  out  32  ALU result

## Operation
- **Reset:** out_valid=0, out_we=0, out_rd=0, out_result=0, flags_nzcv=4'b0000. After reset in_ready=1.
- **Handshake:** in_ready = !flush & (!out_valid | out_ready). Output register is a single stage.
- **Condition pass:**
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V;
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V);
  - AL 1; NV (4'hF) 0.
- **Opcodes:**
  - AND(0): op1&op2
  - EOR(1): op1^op2
  - SUB(2): op1-op2
  - RSB(3): op2-op1
  - ADD(4): op1+op2
  - ADC(5): op1+op2+C
  - SBC(6): op1-op2-!C
  - RSC(7): op2-op1-!C
  - TST(8): AND
  - TEQ(9): EOR
  - CMP(A): SUB
  - CMN(B): ADD
  - ORR(C): op1|op2
  - MOV(D): op2
  - BIC(E): op1&~op2
  - MVN(F): ~op2
- **Arithmetic:** computed in a 33-bit adder as a + ~b + 1 for subtraction.
  - C = bit 32 (for subtracts, C = NOT borrow).
  - V = (a[31]==b'[31]) & (r[31]!=a[31]), where b' is the adder's second input after inversion.
- **Logical ops:** N=r[31], Z=(r==0), C=in_shift_c, V unchanged.
- **Flag commit:** at the accept edge, when the condition passes and (in_s=1 or the opcode is 8–B). Opcodes 8–B update flags regardless of in_s.
- **Output beat:** every accepted beat produces one output beat, including condition-failed beats.
  - out_we = pass & opcode not in 8–B.
  - Condition-failed beat: out_we=0, flags unchanged, out_result = computed value (don't-care to the consumer).
- **rd=15:** treated like any other register. No SPSR restore.
- **Flush:** out_valid is cleared at the next edge; any in-flight input is dropped. Flags already committed are not reverted. Flush has priority over in_valid and out_ready.
- **Reset mid-operation:** all state returns to reset values at the edge; any pending beat is lost.

## Timing
- **Latency:** 1 cycle from accept edge to out_valid.
- **Throughput:** 1 beat per cycle while out_ready=1.
- **Flag visibility:** flags update on the accept edge. A beat accepted in cycle n+1 sees the flags of the beat accepted in cycle n, so there is no hazard bubble.
- **flag_c:** a registered output that changes only on flag-commit edges. The shifter's combinational c_in is therefore stable within a cycle.
- **Backpressure:** out_valid=1 & out_ready=0 holds all out_* stable and forces in_ready=0. Flags do not change while stalled.
- **Simultaneous drain and accept:** when out_valid=1, out_ready=1 and in_valid=1 in the same cycle, the old beat leaves and the new beat loads on the same edge.

## Structure
- **Package arm_dp_pkg:**
  - opcode localparams OP_AND..OP_MVN;
  - condition localparams COND_EQ..COND_NV;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- **Sub-module arm_cond_check:** combinational, inputs (cond[3:0], nzcv[3:0]), output pass. It is reused by the branch and load/store stages.
- **Top module contents:** adder/logic datapath, flag register, output register.

## Test plan
- **Reset:** assert rst 2 cycles → out_valid=0, flags_nzcv=0000, in_ready=1, flag_c=0.
- **ADDS overflow:** ADDS AL, op1=0x7FFFFFFF, op2=1 → next cycle out_result=0x80000000, out_we=1, NZCV=1001.
- **Condition pass/fail:** SUBS 5-5 → result 0, NZCV=0110. Then MOVEQ op2=0x12 → out_we=1, result 0x12. Then MOVNE → out_we=0, flags still 0110.
- **ADC carry chain, TST and CMP:**
  - ADC op1=0xFFFFFFFF, op2=0 with C=1 → result 0, out_we=1, flags unchanged (S=0).
  - TST op1=0xF0, op2=0x0F, shift_c=1 → out_we=0, Z=1, C=1, V preserved.
  - CMP 3,4 → NZCV=1000.
- **Backpressure:** hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_* stable, flags stable. Release → one beat per cycle drains in order.
- **Flush:** beat in output register plus in_valid=1, assert flush → next cycle out_valid=0, input not accepted, previously committed NZCV retained.

Source files
------------

// File: rtl/arm_dp_pkg.sv
// Shared constants for the ARM data-processing execute path.
// Provides opcode and condition encodings, NZCV bit indices and the
// writeback beat payload used by dp_alu_stage.
package arm_dp_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 4;

   // Data-processing opcodes, instruction bits [24:21]
   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;

   // Condition field encodings, instruction bits [31:28]
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   // Bit positions inside the {N,Z,C,V} flag vector
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   // Writeback beat held in the output register
   typedef struct packed {
      logic              we;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] result;
   } wb_beat_t;

   // TST/TEQ/CMP/CMN: always set flags, never write a register
   function automatic logic is_compare_op(input logic [3:0] op);
      return op[3:2] == 2'b10;
   endfunction

endpackage

// File: rtl/dp_alu_stage_if.sv
// Decoded-beat input and writeback-beat output bundle of dp_alu_stage.
// slave : the ALU stage (consumes in_*, produces out_*)
// master: the surrounding pipeline (shifter upstream, regfile downstream)
interface dp_alu_stage_if;
   import arm_dp_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_cond;
   logic [3:0]        in_opcode;
   logic              in_s;
   logic [REG_W-1:0]  in_rd;
   logic [DATA_W-1:0] in_op1;
   logic [DATA_W-1:0] in_op2;
   logic              in_shift_c;

   logic              out_valid;
   logic              out_ready;
   logic              out_we;
   logic [REG_W-1:0]  out_rd;
   logic [DATA_W-1:0] out_result;

   modport slave (
      input  in_valid, in_cond, in_opcode, in_s, in_rd, in_op1, in_op2, in_shift_c,
      input  out_ready,
      output in_ready,
      output out_valid, out_we, out_rd, out_result
   );

   modport master (
      output in_valid, in_cond, in_opcode, in_s, in_rd, in_op1, in_op2, in_shift_c,
      output out_ready,
      input  in_ready,
      input  out_valid, out_we, out_rd, out_result
   );
endinterface

// File: rtl/arm_cond_check.sv
// ARM condition-code evaluator; purely combinational.
// cond : condition field [31:28]
// nzcv : current flags {N,Z,C,V}
// pass : 1 when the instruction should execute
module arm_cond_check
   import arm_dp_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;

   always_comb begin
      n    = nzcv[FLAG_N];
      z    = nzcv[FLAG_Z];
      c    = nzcv[FLAG_C];
      v    = nzcv[FLAG_V];
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c & !z;
         COND_LS: pass = !c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;   // NV never executes
      endcase
   end

endmodule

// File: rtl/dp_alu_stage.sv
// ARM data-processing execute stage.
// clk, rst   : clock, synchronous active-high reset
// flush      : drop the pending writeback beat and block acceptance
// bus        : decoded input beat and registered writeback beat (valid/ready)
// flag_c     : registered C flag, feeds the op2 shifter carry-in
// flags_nzcv : architectural {N,Z,C,V}
module dp_alu_stage
   import arm_dp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   dp_alu_stage_if.slave     bus,
   output logic              flag_c,
   output logic [3:0]        flags_nzcv
);

   logic [3:0]        flags_q, flags_d;
   wb_beat_t          wb_q, wb_d;
   logic              out_valid_q, out_valid_d;

   logic              in_ready_c;
   logic              accept;
   logic              pass;
   logic              arith;
   logic              cin;
   logic [DATA_W-1:0] add_a, add_b;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] result;
   logic              ovf;
   logic              commit;

   arm_cond_check u_cond (
      .cond (bus.in_cond),
      .nzcv (flags_q),
      .pass (pass)
   );

   // Single output stage: free when empty or draining this cycle
   assign in_ready_c = !flush & (!out_valid_q | bus.out_ready);
   assign accept     = bus.in_valid & in_ready_c;

   // Adder operand selection; subtraction is a + ~b + carry
   always_comb begin
      add_a = bus.in_op1;
      add_b = bus.in_op2;
      cin   = 1'b0;
      arith = 1'b0;
      case (bus.in_opcode)
         OP_SUB, OP_CMP: begin add_b = ~bus.in_op2; cin = 1'b1; arith = 1'b1; end
         OP_RSB: begin add_a = bus.in_op2; add_b = ~bus.in_op1; cin = 1'b1; arith = 1'b1; end
         OP_ADD, OP_CMN: arith = 1'b1;
         OP_ADC: begin cin = flags_q[FLAG_C]; arith = 1'b1; end
         OP_SBC: begin add_b = ~bus.in_op2; cin = flags_q[FLAG_C]; arith = 1'b1; end
         OP_RSC: begin add_a = bus.in_op2; add_b = ~bus.in_op1; cin = flags_q[FLAG_C]; arith = 1'b1; end
         default: ;
      endcase
      sum = {1'b0, add_a} + {1'b0, add_b} + (DATA_W+1)'(cin);
      ovf = (add_a[DATA_W-1] == add_b[DATA_W-1]) & (sum[DATA_W-1] != add_a[DATA_W-1]);
   end

   // Result mux
   always_comb begin
      result = sum[DATA_W-1:0];
      case (bus.in_opcode)
         OP_AND, OP_TST: result = bus.in_op1 & bus.in_op2;
         OP_EOR, OP_TEQ: result = bus.in_op1 ^ bus.in_op2;
         OP_ORR:         result = bus.in_op1 | bus.in_op2;
         OP_MOV:         result = bus.in_op2;
         OP_BIC:         result = bus.in_op1 & ~bus.in_op2;
         OP_MVN:         result = ~bus.in_op2;
         default: ;
      endcase
   end

   // Next-state: flag commit and output register
   always_comb begin
      flags_d     = flags_q;
      wb_d        = wb_q;
      out_valid_d = out_valid_q;
      commit      = accept & pass & (bus.in_s | is_compare_op(bus.in_opcode));

      if (commit) begin
         flags_d[FLAG_N] = result[DATA_W-1];
         flags_d[FLAG_Z] = (result == '0);
         flags_d[FLAG_C] = arith ? sum[DATA_W] : bus.in_shift_c;
         flags_d[FLAG_V] = arith ? ovf : flags_q[FLAG_V];
      end

      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         wb_d.we     = pass & !is_compare_op(bus.in_opcode);
         wb_d.rd     = bus.in_rd;
         wb_d.result = result;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q     <= '0;
         wb_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         flags_q     <= flags_d;
         wb_q        <= wb_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_we     = wb_q.we;
   assign bus.out_rd     = wb_q.rd;
   assign bus.out_result = wb_q.result;
   assign flags_nzcv     = flags_q;
   assign flag_c         = flags_q[FLAG_C];

endmodule

// File: tb/tb_dp_alu_stage.sv
// Directed scoreboard bench for dp_alu_stage.
module tb_dp_alu_stage;
   import arm_dp_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       flag_c;
   logic [3:0] flags_nzcv;

   dp_alu_stage_if dif ();

   dp_alu_stage dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .bus        (dif),
      .flag_c     (flag_c),
      .flags_nzcv (flags_nzcv)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [3:0]  rd;
      logic [31:0] res;
      logic [3:0]  nzcv;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   // Present one beat and hold it until accepted; push its expected writeback
   task automatic issue(input logic [3:0] cond, input logic [3:0] op, input logic s,
                        input logic [3:0] rd, input logic [31:0] op1, input logic [31:0] op2,
                        input logic shc, input logic e_we, input logic [31:0] e_res,
                        input logic [3:0] e_nzcv);
      bit done = 1'b0;
      dif.in_cond    = cond;
      dif.in_opcode  = op;
      dif.in_s       = s;
      dif.in_rd      = rd;
      dif.in_op1     = op1;
      dif.in_op2     = op2;
      dif.in_shift_c = shc;
      dif.in_valid   = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (dif.in_ready) begin
            sb.push_back('{e_we, rd, e_res, e_nzcv});
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      dif.in_valid = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout rd=%0d not accepted within 20 cycles", rd);
      end
   endtask

   // Monitor: compare every beat that leaves the stage against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && dif.out_valid && dif.out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat rd=%0d result=0x%08h", dif.out_rd, dif.out_result);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_we", 32'(dif.out_we), 32'(e.we));
               chk("out_rd", 32'(dif.out_rd), 32'(e.rd));
               chk("out_result", dif.out_result, e.res);
               chk("nzcv", 32'(flags_nzcv), 32'(e.nzcv));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst            = 1'b1;
      flush          = 1'b0;
      dif.in_valid   = 1'b0;
      dif.in_cond    = 4'h0;
      dif.in_opcode  = 4'h0;
      dif.in_s       = 1'b0;
      dif.in_rd      = 4'h0;
      dif.in_op1     = 32'h0;
      dif.in_op2     = 32'h0;
      dif.in_shift_c = 1'b0;
      dif.out_ready  = 1'b1;
      idle(2);
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
      chk("rst_out_we", 32'(dif.out_we), 32'd0);
      chk("rst_out_result", dif.out_result, 32'd0);
      chk("rst_flags", 32'(flags_nzcv), 32'd0);
      chk("rst_in_ready", 32'(dif.in_ready), 32'd1);
      chk("rst_flag_c", 32'(flag_c), 32'd0);
      @(posedge clk); #1;

      // Back-to-back stream: cond  op     s  rd  op1           op2           shc we res           nzcv
      issue(COND_AL, OP_ADD, 1, 1,  32'h7FFFFFFF, 32'h1,        0, 1, 32'h80000000, 4'b1001);
      issue(COND_AL, OP_SUB, 1, 2,  32'd5,        32'd5,        0, 1, 32'h0,        4'b0110);
      issue(COND_EQ, OP_MOV, 0, 3,  32'h0,        32'h12,       0, 1, 32'h12,       4'b0110);
      issue(COND_NE, OP_MOV, 0, 4,  32'h0,        32'h34,       0, 0, 32'h34,       4'b0110);
      issue(COND_AL, OP_ADC, 0, 5,  32'hFFFFFFFF, 32'h0,        0, 1, 32'h0,        4'b0110);
      issue(COND_AL, OP_ADD, 1, 6,  32'h7FFFFFFF, 32'h1,        0, 1, 32'h80000000, 4'b1001);
      issue(COND_AL, OP_TST, 0, 7,  32'hF0,       32'h0F,       1, 0, 32'h0,        4'b0111);
      issue(COND_AL, OP_CMP, 0, 8,  32'd3,        32'd4,        0, 0, 32'hFFFFFFFF, 4'b1000);
      issue(COND_AL, OP_RSB, 1, 9,  32'd1,        32'd0,        0, 1, 32'hFFFFFFFF, 4'b1000);
      issue(COND_AL, OP_SBC, 0, 10, 32'hA,        32'h3,        0, 1, 32'h6,        4'b1000);
      issue(COND_NV, OP_ORR, 1, 11, 32'h1,        32'h2,        0, 0, 32'h3,        4'b1000);
      issue(COND_LT, OP_BIC, 1, 12, 32'hFF,       32'h0F,       0, 1, 32'hF0,       4'b0000);
      issue(COND_AL, OP_MVN, 1, 13, 32'h0,        32'h0,        1, 1, 32'hFFFFFFFF, 4'b1010);
      issue(COND_AL, OP_CMN, 0, 14, 32'hFFFFFFFF, 32'h1,        0, 0, 32'h0,        4'b0110);
      issue(COND_HI, OP_EOR, 1, 15, 32'h5,        32'h5,        0, 0, 32'h0,        4'b0110);
      issue(COND_LS, OP_EOR, 1, 15, 32'hF0,       32'h0F,       0, 1, 32'hFF,       4'b0000);
      idle(3);

      // Backpressure: beat A stuck in the output register, beat B waiting
      dif.out_ready = 1'b0;
      issue(COND_AL, OP_ADD, 0, 8, 32'd1, 32'd2, 0, 1, 32'd3, 4'b0000);
      dif.in_cond   = COND_AL;
      dif.in_opcode = OP_ORR;
      dif.in_s      = 1'b0;
      dif.in_rd     = 4'd9;
      dif.in_op1    = 32'h1;
      dif.in_op2    = 32'h4;
      dif.in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(dif.in_ready), 32'd0);
         chk("stall_out_valid", 32'(dif.out_valid), 32'd1);
         chk("stall_out_rd", 32'(dif.out_rd), 32'd8);
         chk("stall_out_result", dif.out_result, 32'd3);
         chk("stall_flags", 32'(flags_nzcv), 32'd0);
         @(posedge clk); #1;
      end
      dif.out_ready = 1'b1;
      @(negedge clk);
      chk("drain_in_ready", 32'(dif.in_ready), 32'd1);
      sb.push_back('{1'b1, 4'd9, 32'd5, 4'b0000});
      @(posedge clk); #1;
      dif.in_valid = 1'b0;
      issue(COND_AL, OP_SUB, 0, 10, 32'd9, 32'd4, 0, 1, 32'd5, 4'b0000);
      idle(3);

      // Flush: pending beat D is dropped, flagged input E is refused
      dif.out_ready = 1'b0;
      issue(COND_AL, OP_ADD, 1, 11, 32'h7FFFFFFF, 32'h1, 0, 1, 32'h80000000, 4'b1001);
      dif.in_cond   = COND_AL;
      dif.in_opcode = OP_MOV;
      dif.in_s      = 1'b1;
      dif.in_rd     = 4'd12;
      dif.in_op2    = 32'h0;
      dif.in_valid  = 1'b1;
      flush         = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 32'(dif.in_ready), 32'd0);
      @(posedge clk); #1;
      flush        = 1'b0;
      dif.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 32'(dif.out_valid), 32'd0);
      chk("flush_flags", 32'(flags_nzcv), 32'b1001);
      chk("flush_flag_c", 32'(flag_c), 32'd0);
      if (sb.size() != 0) void'(sb.pop_back());
      @(posedge clk); #1;
      dif.out_ready = 1'b1;
      issue(COND_AL, OP_MOV, 0, 13, 32'h0, 32'h55, 0, 1, 32'h55, 4'b1001);

      // Let the scoreboard empty, bounded
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
